// File: rtl/jt053246_draw.sv
// Sprite tile drawer: fetches one 16-pixel tile row from ROM (two 32-bit
// words), then writes zoomed pixels into the line buffer.
// Ports:
//   clk, rst          clock, async active-high reset
//   dr_start/dr_busy  draw request / drawer occupied
//   code, attr, hflip, vflip, hpos, ysub, hzoom, hz_keep   tile parameters
//   rom_addr/rom_cs/rom_data/rom_ok   tile ROM word interface
//   buf_addr/buf_din/buf_we           line buffer write port
module jt053246_draw (
    input  logic        clk,
    input  logic        rst,
    input  logic        dr_start,
    output logic        dr_busy,
    input  logic [15:0] code,
    input  logic [9:0]  attr,
    input  logic        hflip,
    input  logic        vflip,
    input  logic [8:0]  hpos,
    input  logic [3:0]  ysub,
    input  logic [9:0]  hzoom,
    input  logic        hz_keep,
    output logic [20:0] rom_addr,
    output logic        rom_cs,
    input  logic [31:0] rom_data,
    input  logic        rom_ok,
    output logic [8:0]  buf_addr,
    output logic [13:0] buf_din,
    output logic        buf_we
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH0,
        FETCH1,
        DRAW
    } state_t;

    state_t      st, st_nx;

    logic [15:0] code_l;
    logic [9:0]  attr_l;
    logic        hflip_l;
    logic [3:0]  vrow_l;
    logic [8:0]  hpos_l;
    logic [9:0]  step_l;
    logic        keep_l;
    logic [31:0] d0, d1;
    logic        gap;
    logic [15:0] acc;
    logic [15:0] acc_nx;
    logic [8:0]  x;
    logic [8:0]  cnt;
    logic        h;
    logic [63:0] row;
    logic [3:0]  slot;
    logic [5:0]  base;
    logic [3:0]  pix;
    logic        draw_go;

    // With hflip the first fetch holds the right half of the tile, so the
    // halves are swapped back and the slot index mirrored.
    assign acc_nx = acc + {6'd0, step_l};
    assign row    = hflip_l ? {d1, d0} : {d0, d1};
    assign slot   = hflip_l ? ~acc[9:6] : acc[9:6];
    assign base   = 6'd63 - {slot, 2'b00};
    assign pix    = row[base -: 4];

    assign rom_addr = {code_l, vrow_l, h};
    assign buf_addr = x;
    assign buf_din  = {attr_l, pix};

    // Second fetch completes only after the one-cycle chip-select gap
    assign draw_go = (st == FETCH1) && rom_ok && !gap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx   = st;
        rom_cs  = 1'b0;
        h       = 1'b0;
        buf_we  = 1'b0;
        dr_busy = (st != IDLE);
        unique case (st)
            IDLE: begin
                if (dr_start) st_nx = FETCH0;
            end
            FETCH0: begin
                rom_cs = 1'b1;
                h      = hflip_l;
                if (rom_ok) st_nx = FETCH1;
            end
            FETCH1: begin
                rom_cs = !gap;
                h      = ~hflip_l;
                if (rom_ok && !gap) st_nx = DRAW;
            end
            DRAW: begin
                buf_we = (pix != 4'd0);
                // Leave on the last pixel cycle so no idle DRAW cycle follows
                if (acc_nx >= 16'd1024 || cnt == 9'd510) st_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_l  <= 16'd0;
            attr_l  <= 10'd0;
            hflip_l <= 1'b0;
            vrow_l  <= 4'd0;
            hpos_l  <= 9'd0;
            step_l  <= 10'd0;
            keep_l  <= 1'b0;
            d0      <= 32'd0;
            d1      <= 32'd0;
            gap     <= 1'b0;
            acc     <= 16'd0;
            x       <= 9'd0;
            cnt     <= 9'd0;
        end else begin
            gap <= (st == FETCH0) && rom_ok;
            if (st == IDLE && dr_start) begin
                code_l  <= code;
                attr_l  <= attr;
                hflip_l <= hflip;
                vrow_l  <= ysub ^ {4{vflip}};
                hpos_l  <= hpos;
                step_l  <= (hzoom == 10'd0) ? 10'd1 : hzoom;
                keep_l  <= hz_keep;
            end
            if (st == FETCH0 && rom_ok) d0 <= rom_data;
            if (draw_go) begin
                d1  <= rom_data;
                cnt <= 9'd0;
                // Continuing tiles keep the sub-pixel fraction and position
                acc <= keep_l ? {6'd0, acc[9:0]} : 16'd0;
                x   <= keep_l ? x : hpos_l;
            end
            if (st == DRAW) begin
                acc <= acc_nx;
                x   <= x + 9'd1;
                cnt <= cnt + 9'd1;
            end
        end
    end

endmodule
